// File: rtl/simon_dec_iter_if.sv
// Stream bundle for the Simon 32/64 decryption core: key load, ciphertext in, plaintext out.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready and out_valid/out_ready handshakes; key_load is a bare strobe.
// Ports: key_load/key_in/key_ready (key path), in_valid/in_ready/in_data (ciphertext),
//        out_valid/out_ready/out_data (plaintext). master = producer/consumer side, slave = core.
interface simon_dec_iter_if;
  logic        key_load;
  logic [63:0] key_in;
  logic        key_ready;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  modport master (
    output key_load, key_in, in_valid, in_data, out_ready,
    input  key_ready, in_ready, out_valid, out_data
  );

  modport slave (
    input  key_load, key_in, in_valid, in_data, out_ready,
    output key_ready, in_ready, out_valid, out_data
  );
endinterface

// File: rtl/simon_dec_iter.sv
// Iterative Simon 32/64 decryption: own forward key expansion, then one inverse round per clock.
// Latency: key_ready 28 cycles after key_load; out_valid 32 cycles after input acceptance.
// Backpressure: holds the result in DONE until out_ready; no new input accepted until then.
// Ports: clk, rst_n (async active-low), bus (simon_dec_iter_if.slave: key, cipher in, plain out).
module simon_dec_iter #(
  parameter int ROUNDS    = 32,
  parameter int KEY_WORDS = 4
) (
  input logic             clk,
  input logic             rst_n,
  simon_dec_iter_if.slave bus
);

  localparam logic [2:0] NOKEY  = 3'd0;
  localparam logic [2:0] KEYEXP = 3'd1;
  localparam logic [2:0] IDLE   = 3'd2;
  localparam logic [2:0] DEC    = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  // Last expansion step index (computes k31) and last round counter value.
  localparam logic [4:0] EXP_LAST = 5'(ROUNDS - KEY_WORDS - 1);
  localparam logic [4:0] RND_LAST = 5'(ROUNDS - 1);

  localparam logic [15:0] KEY_C = 16'hFFFC;
  // z0 sequence; step j uses the j-th bit counted from the left, i.e. Z0[61-j].
  localparam logic [61:0] Z0 =
    62'b11111010001001010110000111001101111101000100101011000011100110;

  logic [2:0]  state;
  logic [4:0]  cnt;       // expansion step in KEYEXP, round index in DEC
  logic [15:0] x;
  logic [15:0] y;
  logic [15:0] ks [32];   // round-key store, validity tracked by state only

  logic        key_accept;
  logic [5:0]  z_idx;
  logic [15:0] t;
  logic [15:0] k_new;
  logic [15:0] rk;
  logic [15:0] fy;

  function automatic logic [15:0] simon_f(input logic [15:0] a);
    return ({a[14:0], a[15]} & {a[7:0], a[15:8]}) ^ {a[13:0], a[15:14]};
  endfunction

  // key_load is honoured only while no block is in flight.
  assign key_accept = bus.key_load &&
                      ((state == NOKEY) || (state == KEYEXP) || (state == IDLE));

  // Forward expansion step: k[i+4] from k[i], k[i+1], k[i+3] with i = cnt.
  always_comb begin
    z_idx = 6'd61 - {1'b0, cnt};
    t     = {ks[cnt + 5'd3][2:0], ks[cnt + 5'd3][15:3]} ^ ks[cnt + 5'd1];
    k_new = KEY_C ^ {15'd0, Z0[z_idx]} ^ ks[cnt] ^ t ^ {t[0], t[15:1]};
  end

  // Keys are consumed in reverse: round cnt (0-based) uses k[31-cnt].
  assign rk = ks[RND_LAST - cnt];
  assign fy = simon_f(y);

  always_ff @(posedge clk) begin
    if (key_accept) begin
      ks[0] <= bus.key_in[15:0];
      ks[1] <= bus.key_in[31:16];
      ks[2] <= bus.key_in[47:32];
      ks[3] <= bus.key_in[63:48];
    end else if (state == KEYEXP) begin
      ks[cnt + 5'd4] <= k_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= NOKEY;
      cnt   <= 5'd0;
      x     <= 16'd0;
      y     <= 16'd0;
    end else begin
      case (state)
        NOKEY: begin
          if (bus.key_load) begin
            state <= KEYEXP;
            cnt   <= 5'd0;
          end
        end
        KEYEXP: begin
          if (bus.key_load) begin
            cnt <= 5'd0;                // restart with the new key
          end else if (cnt == EXP_LAST) begin
            state <= IDLE;
            cnt   <= 5'd0;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        IDLE: begin
          // key_load wins over an input handshake in the same cycle.
          if (bus.key_load) begin
            state <= KEYEXP;
            cnt   <= 5'd0;
          end else if (bus.in_valid) begin
            x     <= bus.in_data[31:16];
            y     <= bus.in_data[15:0];
            cnt   <= 5'd0;
            state <= DEC;
          end
        end
        DEC: begin
          x <= y;
          y <= x ^ fy ^ rk;
          if (cnt == RND_LAST) begin
            state <= DONE;
            cnt   <= 5'd0;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= NOKEY;
          cnt   <= 5'd0;
        end
      endcase
    end
  end

  assign bus.key_ready = (state == IDLE) || (state == DEC) || (state == DONE);
  assign bus.in_ready  = (state == IDLE) && !bus.key_load;
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = (state == DONE) ? {x, y} : 32'd0;

endmodule
